// File: rtl/add_multiword_serial.sv
// add_multiword_serial: word-serial multi-precision adder built around one carry-chained word adder
module add_carry_inout_overflow #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  assign {carry_out, sum} = {1'b0, in0} + {1'b0, in1} + {{WIDTH{1'b0}}, carry_in};
  assign overflow = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in0[WIDTH-1]);
endmodule

module add_multiword_serial #(
  parameter int WIDTH     = 16,
  parameter int NUM_WORDS = 4,
  parameter int TOTAL     = WIDTH * NUM_WORDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [TOTAL-1:0] in0,
  input  logic [TOTAL-1:0] in1,
  input  logic             carry_in,
  output logic [TOTAL-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);
  // Encoding keeps busy/done as direct state flop bits, so they stay glitch-free.
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;
  state_t state_q, state_d;
  logic [TOTAL-1:0] op0, op1;
  logic [IW-1:0] idx;
  logic carry_q, last;
  logic [WIDTH-1:0] w_in0, w_in1, w_sum;
  logic w_co, w_ov;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == BUSY) ? (last ? DONE : BUSY) : (go ? BUSY : state_q);
  always_comb begin
    busy  = state_q[0];
    done  = state_q[1];
    last  = (idx == LAST);
    w_in0 = op0[int'(idx) * WIDTH +: WIDTH];
    w_in1 = op1[int'(idx) * WIDTH +: WIDTH];
  end
  add_carry_inout_overflow #(.WIDTH(WIDTH)) u_add (
    .in0(w_in0), .in1(w_in1), .carry_in(carry_q),
    .sum(w_sum), .carry_out(w_co), .overflow(w_ov)
  );
  // Index wraps to 0 on the last word so it never leaves 0..NUM_WORDS-1.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op0       <= '0;
      op1       <= '0;
      idx       <= '0;
      carry_q   <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state_q == BUSY) begin
      sum[int'(idx) * WIDTH +: WIDTH] <= w_sum;
      carry_q <= w_co;
      idx     <= last ? '0 : idx + 1'b1;
      if (last) begin
        carry_out <= w_co;
        overflow  <= w_ov;
      end
    end else if (go) begin
      op0     <= in0;
      op1     <= in1;
      carry_q <= carry_in;
      idx     <= '0;
    end
endmodule

// File: tb/tb_add_multiword_serial.sv
// tb_add_multiword_serial: directed and random scoreboard bench for NUM_WORDS=4 and NUM_WORDS=1
module tb_add_multiword_serial;
  typedef struct {logic [64:0] cs; logic ov;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic go4, ci4, co4, ov4, busy4, done4;
  logic [63:0] a4, b4, sum4;
  logic go1, ci1, co1, ov1, busy1, done1;
  logic [15:0] a1, b1, sum1;
  exp_t sb[$];
  int vectors = 0;
  int errs = 0;

  add_multiword_serial #(.WIDTH(16), .NUM_WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .go(go4), .in0(a4), .in1(b4), .carry_in(ci4),
    .sum(sum4), .carry_out(co4), .overflow(ov4), .busy(busy4), .done(done4)
  );
  add_multiword_serial #(.WIDTH(16), .NUM_WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .go(go1), .in0(a1), .in1(b1), .carry_in(ci1),
    .sum(sum1), .carry_out(co1), .overflow(ov1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit w, input logic [63:0] a, input logic [63:0] b, input logic ci);
    exp_t e;
    logic [16:0] t;
    if (w) begin
      a4 = a; b4 = b; ci4 = ci; go4 = 1'b1;
      e.cs = {1'b0, a} + {1'b0, b} + 65'(ci);
      e.ov = (a[63] == b[63]) && (e.cs[63] != a[63]);
    end else begin
      a1 = a[15:0]; b1 = b[15:0]; ci1 = ci; go1 = 1'b1;
      t = {1'b0, a[15:0]} + {1'b0, b[15:0]} + 17'(ci);
      e.cs = 65'(t);
      e.ov = (a[15] == b[15]) && (t[15] != a[15]);
    end
    sb.push_back(e);
    step();
    go4 = 1'b0;
    go1 = 1'b0;
    check("accept_busy", w ? busy4 : busy1, 65'(1));
    check("accept_done", w ? done4 : done1, 65'(0));
  endtask

  task automatic wait_done(input bit w, input int need, input int n0);
    exp_t e;
    int n = n0;
    while (!(w ? done4 : done1) && n < need + 8) begin
      check("busy_during", w ? busy4 : busy1, 65'(1));
      step();
      n++;
    end
    check("latency", 65'(n), 65'(need));
    check("busy_after", w ? busy4 : busy1, 65'(0));
    if (sb.size() == 0) begin
      errs++;
      $error("FAIL scoreboard: observed empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      check("carry_sum", w ? {co4, sum4} : {48'b0, co1, sum1}, e.cs);
      check("overflow", w ? ov4 : ov1, 65'(e.ov));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    go4 = 0; go1 = 0; ci4 = 0; ci1 = 0;
    a4 = '0; b4 = '0; a1 = '0; b1 = '0;
    #12;
    check("rst_sum4", sum4, 65'(0));
    check("rst_flags4", {co4, ov4, busy4, done4}, 65'(0));
    check("rst_out1", {co1, ov1, busy1, done1, sum1}, 65'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start(1, 64'h0000_0000_0000_FFFF, 64'h1, 0);
    wait_done(1, 4, 0);
    check("ripple_sum", sum4, 65'h0000_0000_0001_0000);
    check("ripple_cf", {co4, ov4}, 65'(0));
    start(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1);
    wait_done(1, 4, 0);
    check("full_sum", sum4, 65'(0));
    check("full_co", co4, 65'(1));
    start(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0);
    wait_done(1, 4, 0);
    check("pos_ovf_sum", sum4, 65'h8000_0000_0000_0000);
    check("pos_ovf", {co4, ov4}, 65'b01);
    start(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0);
    wait_done(1, 4, 0);
    check("neg_ovf", {co4, ov4, sum4}, {2'b11, 64'h0});
    step();
    step();
    check("hold_done", {busy4, done4}, 65'b01);
    check("hold_sum", {co4, ov4, sum4}, {2'b11, 64'h0});
    start(1, 64'h5, 64'h7, 0);
    step();
    a4 = 64'hFF; b4 = 64'hFF; go4 = 1'b1;
    step();
    go4 = 1'b0;
    wait_done(1, 4, 2);
    check("busy_go_sum", sum4, 65'd12);
    start(1, 64'h3, 64'h4, 1);
    wait_done(1, 4, 0);
    check("restart_sum", sum4, 65'd8);
    start(1, 64'h1234, 64'h5678, 0);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sum", sum4, 65'(0));
    check("mid_rst_flags", {co4, ov4, busy4, done4}, 65'(0));
    sb.delete();
    #2 rst_n = 1'b1;
    step();
    check("post_rst_idle", {busy4, done4}, 65'(0));
    start(1, 64'h1, 64'h2, 0);
    wait_done(1, 4, 0);
    check("post_rst_sum", sum4, 65'd3);
    for (int i = 0; i < 1000; i++) begin
      start(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      wait_done(1, 4, 0);
    end
    start(0, 64'h7FFF, 64'h1, 0);
    wait_done(0, 1, 0);
    check("nw1_ovf", {co1, ov1, sum1}, {2'b01, 16'h8000});
    for (int i = 0; i < 1000; i++) begin
      start(0, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)));
      wait_done(0, 1, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
